// File: rtl/i2c_reg_access_ctrl_pkg.sv
// rtl/i2c_reg_access_ctrl_pkg.sv - shared constants, types and byte-step helpers
// Purpose: I2C master core register map, CR/SR bit positions, command bytes,
//          error codes, sequencer states and per-step TXR/CR byte selection.
package i2c_reg_access_ctrl_pkg;

    // Core register addresses (TXR/RXR and CR/SR share addresses).
    localparam logic [2:0] REG_PRER_LO = 3'd0;
    localparam logic [2:0] REG_PRER_HI = 3'd1;
    localparam logic [2:0] REG_CTR     = 3'd2;
    localparam logic [2:0] REG_TXR     = 3'd3;
    localparam logic [2:0] REG_RXR     = 3'd3;
    localparam logic [2:0] REG_CR      = 3'd4;
    localparam logic [2:0] REG_SR      = 3'd4;

    // CR bits
    localparam int CR_STA  = 7;
    localparam int CR_STO  = 6;
    localparam int CR_RD   = 5;
    localparam int CR_WR   = 4;
    localparam int CR_ACK  = 3;
    localparam int CR_IACK = 0;

    // SR bits
    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;
    localparam int SR_IF    = 0;

    localparam logic [7:0] CTR_DISABLE = 8'h00;
    localparam logic [7:0] CTR_ENABLE  = 8'h80;

    localparam logic [7:0] CMD_STA_WR     = 8'h90;
    localparam logic [7:0] CMD_WR         = 8'h10;
    localparam logic [7:0] CMD_WR_STO     = 8'h50;
    localparam logic [7:0] CMD_RD_NAK_STO = 8'h68;
    localparam logic [7:0] CMD_STO        = 8'h40;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_AL      = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_TXR,
        ST_CR,
        ST_POLL,
        ST_RXR,
        ST_STO,
        ST_RESP
    } state_t;

    // Byte loaded into TXR for a step. Read step 3 has no TXR load.
    function automatic logic [7:0] step_txr(input logic rd, input logic [1:0] step,
                                            input logic [6:0] dev, input logic [7:0] regad,
                                            input logic [7:0] wdata);
        logic [7:0] b;
        case (step)
            2'd0:    b = {dev, 1'b0};
            2'd1:    b = regad;
            2'd2:    b = rd ? {dev, 1'b1} : wdata;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Command written to CR for a step.
    function automatic logic [7:0] step_cmd(input logic rd, input logic [1:0] step);
        logic [7:0] c;
        case (step)
            2'd0:    c = CMD_STA_WR;
            2'd1:    c = CMD_WR;
            2'd2:    c = rd ? CMD_STA_WR : CMD_WR_STO;
            default: c = CMD_RD_NAK_STO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_reg_access_ctrl_if.sv
// rtl/i2c_reg_access_ctrl_if.sv - request/response and core register bus bundle
// Purpose: groups the firmware request/response handshake and the stb/ack bus
//          towards the I2C master core.
// master: the sequencer (drives req_ready, rsp_*, m_adr_o/m_dat_o/m_we_o/m_stb_o)
// slave : environment (drives req_*, m_dat_i, m_ack_i)
interface i2c_reg_access_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_we_o;
    logic       m_stb_o;
    logic       m_ack_i;

    modport master (
        input  req_valid, req_rd, req_dev, req_reg, req_wdata, m_dat_i, m_ack_i,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, m_adr_o, m_dat_o, m_we_o, m_stb_o
    );

    modport slave (
        output req_valid, req_rd, req_dev, req_reg, req_wdata, m_dat_i, m_ack_i,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_adr_o, m_dat_o, m_we_o, m_stb_o
    );
endinterface

// File: rtl/i2c_reg_access_ctrl_bus_op.sv
// rtl/i2c_reg_access_ctrl_bus_op.sv - single stb/ack register transaction engine
// Purpose: on start_i (while idle) registers adr/dat/we and raises m_stb_o, holds
//          them until m_ack_i, then drops m_stb_o the following cycle.
// Ports: clk_i/rst_i; start_i, adr_i, dat_i, we_i request an op; busy_o while strobing;
//        done_o pulses in the ack cycle with rdata_o = m_dat_i; m_* is the core bus.
module i2c_reg_access_ctrl_bus_op (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] adr_i,
    input  logic [7:0] dat_i,
    input  logic       we_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [2:0] m_adr_o,
    output logic [7:0] m_dat_o,
    output logic       m_we_o,
    output logic       m_stb_o,
    input  logic [7:0] m_dat_i,
    input  logic       m_ack_i
);
    logic       stb_q, stb_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       we_q, we_d;

    always_comb begin
        stb_d = stb_q;
        adr_d = adr_q;
        dat_d = dat_q;
        we_d  = we_q;
        if (stb_q) begin
            if (m_ack_i) begin
                stb_d = 1'b0;
            end
        end else if (start_i) begin
            stb_d = 1'b1;
            adr_d = adr_i;
            dat_d = dat_i;
            we_d  = we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q <= 1'b0;
            adr_q <= 3'd0;
            dat_q <= 8'h00;
            we_q  <= 1'b0;
        end else begin
            stb_q <= stb_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            we_q  <= we_d;
        end
    end

    // Acks outside an active strobe never reach the sequencer.
    assign done_o  = stb_q & m_ack_i;
    assign busy_o  = stb_q;
    assign rdata_o = m_dat_i;
    assign m_stb_o = stb_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;
    assign m_we_o  = we_q;
endmodule

// File: rtl/i2c_reg_access_ctrl.sv
// rtl/i2c_reg_access_ctrl.sv - request sequencer for the OpenCores I2C master core
// Purpose: initialises the core (prescaler, enable), then turns single-register
//          read/write requests into full I2C transactions with one response each.
// Ports: wb_clk_i clock; wb_rst_i sync active-high reset; bus (master modport):
//        req_* request handshake, rsp_* response pulse, m_* core register bus.
module i2c_reg_access_ctrl
    import i2c_reg_access_ctrl_pkg::*;
#(
    parameter logic [15:0] PRESCALE    = 16'd79,
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    i2c_reg_access_ctrl_if.master bus
);
    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [19:0] cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    err_t        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        op_start, op_we, op_busy, op_done;
    logic [2:0]  op_adr;
    logic [7:0]  op_dat, op_rdata;
    logic        last_step;

    i2c_reg_access_ctrl_bus_op u_bus_op (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .start_i (op_start),
        .adr_i   (op_adr),
        .dat_i   (op_dat),
        .we_i    (op_we),
        .busy_o  (op_busy),
        .done_o  (op_done),
        .rdata_o (op_rdata),
        .m_adr_o (bus.m_adr_o),
        .m_dat_o (bus.m_dat_o),
        .m_we_o  (bus.m_we_o),
        .m_stb_o (bus.m_stb_o),
        .m_dat_i (bus.m_dat_i),
        .m_ack_i (bus.m_ack_i)
    );

    assign last_step = rd_q ? (step_q == 2'd3) : (step_q == 2'd2);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        op_start = 1'b0;
        op_we    = 1'b0;
        op_adr   = 3'd0;
        op_dat   = 8'h00;

        case (state_q)
            ST_INIT: begin
                op_we    = 1'b1;
                op_start = ~op_busy;
                case (step_q)
                    2'd0:    begin op_adr = REG_CTR;     op_dat = CTR_DISABLE;    end
                    2'd1:    begin op_adr = REG_PRER_LO; op_dat = PRESCALE[7:0];  end
                    2'd2:    begin op_adr = REG_PRER_HI; op_dat = PRESCALE[15:8]; end
                    default: begin op_adr = REG_CTR;     op_dat = CTR_ENABLE;     end
                endcase
                if (op_done) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                if (bus.req_valid) begin
                    rd_d    = bus.req_rd;
                    dev_d   = bus.req_dev;
                    reg_d   = bus.req_reg;
                    wdata_d = bus.req_wdata;
                    err_d   = ERR_OK;
                    rdata_d = 8'h00;
                    step_d  = 2'd0;
                    state_d = ST_TXR;
                end
            end

            ST_TXR: begin
                op_we    = 1'b1;
                op_adr   = REG_TXR;
                op_dat   = step_txr(rd_q, step_q, dev_q, reg_q, wdata_q);
                op_start = ~op_busy;
                if (op_done) begin
                    state_d = ST_CR;
                end
            end

            ST_CR: begin
                op_we    = 1'b1;
                op_adr   = REG_CR;
                op_dat   = step_cmd(rd_q, step_q);
                op_start = ~op_busy;
                if (op_done) begin
                    cnt_d   = 20'd0;
                    state_d = ST_POLL;
                end
            end

            ST_POLL: begin
                op_adr = REG_SR;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 20'd1;
                end
                if (op_done) begin
                    if (!op_rdata[SR_TIP]) begin
                        if (op_rdata[SR_AL]) begin
                            // Core has already released the bus: no STOP.
                            err_d   = ERR_AL;
                            state_d = ST_RESP;
                        end else if (op_rdata[SR_RXACK] && !(rd_q && step_q == 2'd3)) begin
                            err_d   = ERR_NACK;
                            state_d = ST_STO;
                        end else if (last_step) begin
                            state_d = rd_q ? ST_RXR : ST_RESP;
                        end else begin
                            step_d  = step_q + 2'd1;
                            // Final read byte has no TXR load, straight to CR.
                            state_d = (rd_q && step_q == 2'd2) ? ST_CR : ST_TXR;
                        end
                    end
                end else if (!op_busy) begin
                    // Timeout is only acted on between SR reads so no op is abandoned.
                    if (cnt_q >= TIMEOUT_CYC) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_STO;
                    end else begin
                        op_start = 1'b1;
                    end
                end
            end

            ST_RXR: begin
                op_adr   = REG_RXR;
                op_start = ~op_busy;
                if (op_done) begin
                    rdata_d = op_rdata;
                    state_d = ST_RESP;
                end
            end

            ST_STO: begin
                op_we    = 1'b1;
                op_adr   = REG_CR;
                op_dat   = CMD_STO;
                op_start = ~op_busy;
                if (op_done) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
                step_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_INIT;
            step_q  <= 2'd0;
            cnt_q   <= 20'd0;
            rd_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            err_q   <= ERR_OK;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// tb/tb_i2c_reg_access_ctrl.sv - directed self-checking bench for i2c_reg_access_ctrl
module tb_i2c_reg_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_reg_access_ctrl_if bus ();

    i2c_reg_access_ctrl #(
        .PRESCALE    (16'd79),
        .TIMEOUT_CYC (20'd40)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural core register model: 1-cycle ack, TIP held for two SR reads
    // after each START/WR/RD command, scripted NACK / AL / stuck-SCL.
    logic        ack_q;
    bit          spur = 0;
    bit          stuck = 0;
    int          nack_cr = -1;
    int          al_cr = -1;
    logic [7:0]  rxr_val = 8'h00;
    int          tip_left;
    logic        nack_flag, al_flag;
    int          cr_idx;
    int          sr_reads = 0;
    int          cyc = 0;
    logic [10:0] wlog[$];
    int          wcyc[$];

    assign bus.m_ack_i = ack_q | spur;
    assign bus.m_dat_i = (bus.m_adr_o == 3'd4) ?
                         {nack_flag, 1'b0, al_flag, 3'b000, (stuck || tip_left != 0), 1'b0} :
                         (bus.m_adr_o == 3'd3) ? rxr_val : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ack_q     <= 1'b0;
            tip_left  <= 0;
            nack_flag <= 1'b0;
            al_flag   <= 1'b0;
            cr_idx    <= 0;
        end else begin
            ack_q <= bus.m_stb_o & ~ack_q;
            if (bus.req_valid && bus.req_ready) cr_idx <= 0;
            if (bus.m_stb_o && ack_q) begin
                if (bus.m_we_o) begin
                    wlog.push_back({bus.m_adr_o, bus.m_dat_o});
                    wcyc.push_back(cyc);
                    if (bus.m_adr_o == 3'd4 && (bus.m_dat_o & 8'hB0) != 8'h00) begin
                        tip_left  <= 2;
                        nack_flag <= (cr_idx == nack_cr) || bus.m_dat_o[5];
                        al_flag   <= (cr_idx == al_cr);
                        cr_idx    <= cr_idx + 1;
                    end
                end else if (bus.m_adr_o == 3'd4) begin
                    sr_reads <= sr_reads + 1;
                    if (tip_left > 0) tip_left <= tip_left - 1;
                end
            end
        end
    end

    int rsp_total = 0;
    logic [7:0] last_rdata;
    logic [1:0] last_err;
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            rsp_total  <= rsp_total + 1;
            last_rdata <= bus.rsp_rdata;
            last_err   <= bus.rsp_err;
        end
    end

    function automatic logic [10:0] w(input logic [2:0] a, input logic [7:0] d);
        return {a, d};
    endfunction

    task automatic expect_log(input string tag, input int base, input logic [10:0] exp[$]);
        check({tag, "_len"}, wlog.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < wlog.size()) check($sformatf("%s_%0d", tag, i), wlog[base + i], exp[i]);
        end
    endtask

    int log_base, sr_base, pulses;

    task automatic do_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
        int n;
        int c0;
        log_base = wlog.size();
        sr_base  = sr_reads;
        c0       = rsp_total;
        bus.req_rd    = rd;
        bus.req_dev   = dev;
        bus.req_reg   = rg;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 400) begin @(negedge clk); n++; end
        check("ready_wait", n < 400, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_total == c0 && n < 400) begin @(negedge clk); n++; end
        check("rsp_wait", n < 400, 1);
        repeat (3) @(negedge clk);
        pulses = rsp_total - c0;
    endtask

    logic [10:0] e[$];
    int n, b, r0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rd    = 1'b0;
        bus.req_dev   = 7'd0;
        bus.req_reg   = 8'h00;
        bus.req_wdata = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_stb", bus.m_stb_o, 0);
        check("rst_we", bus.m_we_o, 0);
        check("rst_adr", bus.m_adr_o, 0);
        check("rst_dat", bus.m_dat_o, 0);
        rst = 1'b0;

        // Request presented during INIT; must wait for the init sequence.
        do_req(1'b0, 7'h50, 8'h12, 8'hA5);
        e = {w(2, 8'h00), w(0, 8'h4F), w(1, 8'h00), w(2, 8'h80),
             w(3, 8'hA0), w(4, 8'h90), w(3, 8'h12), w(4, 8'h10), w(3, 8'hA5), w(4, 8'h50)};
        expect_log("init_wr", 0, e);
        check("wr_err", last_err, 2'b00);
        check("wr_rdata", last_rdata, 8'h00);
        check("wr_pulse", pulses, 1);
        check("wr_polls", sr_reads - sr_base, 9);

        // Stray ack while idle is ignored.
        b = wlog.size();
        r0 = rsp_total;
        spur = 1;
        @(negedge clk);
        spur = 0;
        repeat (3) @(negedge clk);
        check("spur_log", wlog.size() - b, 0);
        check("spur_ready", bus.req_ready, 1);
        check("spur_rsp", rsp_total - r0, 0);

        // Read with repeated start; RxACK=1 on the read byte is not an error.
        rxr_val = 8'hA5;
        do_req(1'b1, 7'h50, 8'h12, 8'h00);
        e = {w(3, 8'hA0), w(4, 8'h90), w(3, 8'h12), w(4, 8'h10), w(3, 8'hA1), w(4, 8'h90),
             w(4, 8'h68)};
        expect_log("rd", log_base, e);
        check("rd_err", last_err, 2'b00);
        check("rd_rdata", last_rdata, 8'hA5);
        check("rd_pulse", pulses, 1);
        check("rd_polls", sr_reads - sr_base, 12);

        // Address NACK on absent device.
        nack_cr = 0;
        do_req(1'b0, 7'h21, 8'h12, 8'h33);
        nack_cr = -1;
        e = {w(3, 8'h42), w(4, 8'h90), w(4, 8'h40)};
        expect_log("nack_adr", log_base, e);
        check("nack_adr_err", last_err, 2'b01);
        check("nack_adr_rdata", last_rdata, 8'h00);

        // NACK on the data byte still issues STO.
        nack_cr = 2;
        do_req(1'b0, 7'h50, 8'h34, 8'h5A);
        nack_cr = -1;
        e = {w(3, 8'hA0), w(4, 8'h90), w(3, 8'h34), w(4, 8'h10), w(3, 8'h5A), w(4, 8'h50),
             w(4, 8'h40)};
        expect_log("nack_dat", log_base, e);
        check("nack_dat_err", last_err, 2'b01);

        // Arbitration lost on the register byte: no STO.
        al_cr = 1;
        do_req(1'b0, 7'h50, 8'h01, 8'h02);
        al_cr = -1;
        e = {w(3, 8'hA0), w(4, 8'h90), w(3, 8'h01), w(4, 8'h10)};
        expect_log("al", log_base, e);
        check("al_err", last_err, 2'b10);
        check("al_rdata", last_rdata, 8'h00);

        // TIP never clears: timeout after 40 poll cycles, then STO.
        stuck = 1;
        do_req(1'b0, 7'h50, 8'h02, 8'h03);
        stuck = 0;
        e = {w(3, 8'hA0), w(4, 8'h90), w(4, 8'h40)};
        expect_log("tmo", log_base, e);
        check("tmo_err", last_err, 2'b11);
        check("tmo_polls", sr_reads - sr_base, 14);
        if (wlog.size() >= log_base + 3)
            check("tmo_gap", wcyc[log_base + 2] - wcyc[log_base + 1], 46);
        else
            check("tmo_gap_present", wlog.size() - log_base, 3);

        // Reset during the read data phase: no response, INIT re-runs.
        r0 = rsp_total;
        b = wlog.size();
        bus.req_rd = 1'b1;
        bus.req_dev = 7'h50;
        bus.req_reg = 8'h12;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (wlog.size() < b + 7 && n < 400) begin @(negedge clk); n++; end
        check("mid_reach_data", n < 400, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_ready_low", bus.req_ready, 0);
        do_req(1'b0, 7'h50, 8'h7E, 8'hC3);
        check("mid_no_rsp", rsp_total - r0, 1);
        e = {w(2, 8'h00), w(0, 8'h4F), w(1, 8'h00), w(2, 8'h80),
             w(3, 8'hA0), w(4, 8'h90), w(3, 8'h7E), w(4, 8'h10), w(3, 8'hC3), w(4, 8'h50)};
        expect_log("mid_reinit", log_base, e);
        check("mid_wr_err", last_err, 2'b00);
        check("mid_wr_rdata", last_rdata, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
